// File: rtl/seven_seg_reader_pkg.sv
// Shared definitions for the 7-segment display reader: segment bit positions,
// active-low digit patterns (same set the digit decoder drives) and FSM states.
package seven_seg_reader_pkg;

    localparam int unsigned SegA  = 7;
    localparam int unsigned SegB  = 6;
    localparam int unsigned SegC  = 5;
    localparam int unsigned SegD  = 4;
    localparam int unsigned SegE  = 3;
    localparam int unsigned SegF  = 2;
    localparam int unsigned SegG  = 1;
    localparam int unsigned SegDp = 0;

    // Patterns are {a,b,c,d,e,f,g}, active-low.
    localparam logic [6:0] Pat0     = 7'b0000001;
    localparam logic [6:0] Pat1     = 7'b1001111;
    localparam logic [6:0] Pat2     = 7'b0010010;
    localparam logic [6:0] Pat3     = 7'b0000110;
    localparam logic [6:0] Pat4     = 7'b1001100;
    localparam logic [6:0] Pat5     = 7'b0100100;
    localparam logic [6:0] Pat6     = 7'b0100000;
    localparam logic [6:0] Pat7     = 7'b0001111;
    localparam logic [6:0] Pat8     = 7'b0000000;
    localparam logic [6:0] Pat9     = 7'b0000100;
    localparam logic [6:0] PatBlank = 7'b1111111;

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StCaptured
    } state_e;

endpackage

// File: rtl/seven_seg_reader_pattern_decode.sv
// Maps a 7-bit active-low segment pattern back to its digit value,
// flagging the all-off pattern as blank and anything unrecognised as invalid.
module seven_seg_reader_pattern_decode
    import seven_seg_reader_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_value,
    output logic       o_valid,
    output logic       o_blank
);

    always_comb begin
        o_value = 4'hF;
        o_valid = 1'b1;
        o_blank = 1'b0;
        case (i_pattern)
            Pat0:     o_value = 4'd0;
            Pat1:     o_value = 4'd1;
            Pat2:     o_value = 4'd2;
            Pat3:     o_value = 4'd3;
            Pat4:     o_value = 4'd4;
            Pat5:     o_value = 4'd5;
            Pat6:     o_value = 4'd6;
            Pat7:     o_value = 4'd7;
            Pat8:     o_value = 4'd8;
            Pat9:     o_value = 4'd9;
            PatBlank: begin
                o_valid = 1'b0;
                o_blank = 1'b1;
            end
            default:  o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Monitors a multiplexed active-low 7-segment bus and reconstructs the digit,
// decimal point, blank and error state of each position once it is stable.
module seven_seg_reader
    import seven_seg_reader_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_seg,
    input  logic [DIGITS-1:0]     i_an,
    output logic [4*DIGITS-1:0]   o_value,
    output logic [DIGITS-1:0]     o_dp,
    output logic [DIGITS-1:0]     o_blank,
    output logic [DIGITS-1:0]     o_err,
    output logic [DIGITS-1:0]     o_update,
    output logic                  o_frame_done
);

    localparam logic [CNT_W-1:0] StableCnt = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    logic [7:0]          r_seg_meta;
    logic [7:0]          r_seg_sync;
    logic [DIGITS-1:0]   r_an_meta;
    logic [DIGITS-1:0]   r_an_sync;

    state_e              r_state;
    logic [7:0]          r_sample_seg;
    logic [DIGITS-1:0]   r_sample_an;
    logic [CNT_W-1:0]    r_cnt;
    logic [DIGITS-1:0]   r_seen;

    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_dp;
    logic [DIGITS-1:0]   r_blank;
    logic [DIGITS-1:0]   r_err;
    logic [DIGITS-1:0]   r_update;
    logic                r_frame_done;

    logic [DIGITS-1:0]   w_an_act;
    logic [DIGITS-1:0]   w_sel;
    logic [DIGITS-1:0]   w_seen_next;
    logic                w_an_legal;
    logic                w_match;
    logic                w_frame;
    logic [3:0]          w_dec_value;
    logic                w_dec_valid;
    logic                w_dec_blank;

    // Synchroniser idles high so a reset looks like an inactive bus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg_meta <= '1;
            r_seg_sync <= '1;
            r_an_meta  <= '1;
            r_an_sync  <= '1;
        end else begin
            r_seg_meta <= i_seg;
            r_seg_sync <= r_seg_meta;
            r_an_meta  <= i_an;
            r_an_sync  <= r_an_meta;
        end
    end

    assign w_an_act    = ~r_an_sync;
    assign w_an_legal  = (w_an_act != '0) && ((w_an_act & (w_an_act - DIGITS'(1))) == '0);
    assign w_match     = (r_an_sync == r_sample_an) && (r_seg_sync == r_sample_seg);
    assign w_sel       = ~r_sample_an;
    assign w_seen_next = r_seen | w_sel;
    assign w_frame     = &w_seen_next;

    seven_seg_reader_pattern_decode u_decode (
        .i_pattern (r_sample_seg[SegA:SegG]),
        .o_value   (w_dec_value),
        .o_valid   (w_dec_valid),
        .o_blank   (w_dec_blank)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_sample_seg <= '1;
            r_sample_an  <= '1;
            r_cnt        <= '0;
            r_seen       <= '0;
            r_value      <= '1;
            r_dp         <= '0;
            r_blank      <= '1;
            r_err        <= '0;
            r_update     <= '0;
            r_frame_done <= '0;
        end else begin
            r_update     <= '0;
            r_frame_done <= '0;
            unique case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (w_an_legal) begin
                        r_state      <= StTrack;
                        r_sample_seg <= r_seg_sync;
                        r_sample_an  <= r_an_sync;
                        r_cnt        <= CntOne;
                    end
                end
                StTrack: begin
                    if (r_cnt == StableCnt) begin
                        // Sample has been identical for STABLE_CYCLES: commit it.
                        r_state      <= StCaptured;
                        r_update     <= w_sel;
                        r_frame_done <= w_frame;
                        r_seen       <= w_frame ? '0 : w_seen_next;
                        for (int i = 0; i < DIGITS; i++) begin
                            if (w_sel[i]) begin
                                r_dp[i]  <= ~r_sample_seg[SegDp];
                                r_err[i] <= ~(w_dec_valid | w_dec_blank);
                                if (w_dec_valid || w_dec_blank) begin
                                    r_value[4*i +: 4] <= w_dec_value;
                                    r_blank[i]        <= w_dec_blank;
                                end
                            end
                        end
                    end else if (!w_an_legal) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                    end else if (!w_match) begin
                        r_sample_seg <= r_seg_sync;
                        r_sample_an  <= r_an_sync;
                        r_cnt        <= CntOne;
                    end else begin
                        r_cnt <= r_cnt + CntOne;
                    end
                end
                StCaptured: begin
                    if (!w_an_legal) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                    end else if (!w_match) begin
                        r_state      <= StTrack;
                        r_sample_seg <= r_seg_sync;
                        r_sample_an  <= r_an_sync;
                        r_cnt        <= CntOne;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_value      = r_value;
    assign o_dp         = r_dp;
    assign o_blank      = r_blank;
    assign o_err        = r_err;
    assign o_update     = r_update;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Scoreboard bench for seven_seg_reader: expected captures are queued when a
// digit is presented and checked by a monitor when UPDATE pulses.
module tb_seven_seg_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] o_value;
    logic [3:0]  o_dp;
    logic [3:0]  o_blank;
    logic [3:0]  o_err;
    logic [3:0]  o_update;
    logic        o_frame_done;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0]  upd;
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  err;
        logic        frame;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    logic [15:0] m_value;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    logic [3:0]  m_err;
    logic [3:0]  m_seen;

    seven_seg_reader u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_seg        (seg),
        .i_an         (an),
        .o_value      (o_value),
        .o_dp         (o_dp),
        .o_blank      (o_blank),
        .o_err        (o_err),
        .o_update     (o_update),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model_reset();
        m_value = 16'hFFFF;
        m_dp    = 4'b0000;
        m_blank = 4'b1111;
        m_err   = 4'b0000;
        m_seen  = 4'b0000;
    endfunction

    // Reference model of one capture of digit d showing bus value s.
    function automatic void predict(int d, logic [7:0] s, int at);
        exp_t x;
        logic [3:0] v;
        int kind;  // 0 digit, 1 blank, 2 invalid
        kind = 0;
        v = 4'hF;
        case (s[7:1])
            7'b0000001: v = 4'd0;
            7'b1001111: v = 4'd1;
            7'b0010010: v = 4'd2;
            7'b0000110: v = 4'd3;
            7'b1001100: v = 4'd4;
            7'b0100100: v = 4'd5;
            7'b0100000: v = 4'd6;
            7'b0001111: v = 4'd7;
            7'b0000000: v = 4'd8;
            7'b0000100: v = 4'd9;
            7'b1111111: kind = 1;
            default:    kind = 2;
        endcase
        m_dp[d]  = ~s[0];
        m_err[d] = (kind == 2);
        if (kind != 2) begin
            m_value[4*d +: 4] = v;
            m_blank[d]        = (kind == 1);
        end
        m_seen[d] = 1'b1;
        x.frame = (m_seen == 4'hF);
        if (x.frame) m_seen = 4'h0;
        x.upd   = 4'b0001 << d;
        x.value = m_value;
        x.dp    = m_dp;
        x.blank = m_blank;
        x.err   = m_err;
        x.cyc   = at;
        exp_q.push_back(x);
    endfunction

    always @(negedge clk) begin
        if (rst_n && (o_update != 4'h0 || o_frame_done)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_update: got update=%b frame=%b, required none",
                         o_update, o_frame_done);
            end else begin
                e = exp_q.pop_front();
                if (o_update !== e.upd) begin
                    n_err++;
                    $display("FAIL upd_bits: got %b, required %b", o_update, e.upd);
                end
                n_vec++;
                if (cyc !== e.cyc) begin
                    n_err++;
                    $display("FAIL upd_latency: got cycle %0d, required %0d", cyc, e.cyc);
                end
                n_vec++;
                if (o_value !== e.value) begin
                    n_err++;
                    $display("FAIL upd_value: got %h, required %h", o_value, e.value);
                end
                n_vec++;
                if (o_dp !== e.dp) begin
                    n_err++;
                    $display("FAIL upd_dp: got %b, required %b", o_dp, e.dp);
                end
                n_vec++;
                if (o_blank !== e.blank) begin
                    n_err++;
                    $display("FAIL upd_blank: got %b, required %b", o_blank, e.blank);
                end
                n_vec++;
                if (o_err !== e.err) begin
                    n_err++;
                    $display("FAIL upd_err: got %b, required %b", o_err, e.err);
                end
                n_vec++;
                if (o_frame_done !== e.frame) begin
                    n_err++;
                    $display("FAIL upd_frame: got %b, required %b", o_frame_done, e.frame);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] a, input logic [7:0] s);
        @(negedge clk);
        an  = a;
        seg = s;
    endtask

    task automatic check_drained(input string name);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_missing_update: got %0d pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        an    = 4'b1111;
        seg   = 8'hFF;
        model_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if (o_value !== 16'hFFFF) begin
            n_err++;
            $display("FAIL reset_value: got %h, required ffff", o_value);
        end
        n_vec++;
        if (o_blank !== 4'b1111) begin
            n_err++;
            $display("FAIL reset_blank: got %b, required 1111", o_blank);
        end
        n_vec++;
        if ({o_dp, o_err, o_update, o_frame_done} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_flags: got dp=%b err=%b upd=%b fd=%b, required zeros",
                     o_dp, o_err, o_update, o_frame_done);
        end
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        n_vec++;
        if (o_value !== 16'hFFFF || o_blank !== 4'b1111) begin
            n_err++;
            $display("FAIL idle_hold: got value=%h blank=%b, required ffff 1111", o_value, o_blank);
        end
        check_drained("reset");
    endtask

    task automatic test_single_digit();
        drive(4'b1110, 8'b00001101);
        predict(0, 8'b00001101, cyc + 19);
        repeat (30) @(negedge clk);
        n_vec++;
        if (o_value[3:0] !== 4'd3 || o_dp[0] !== 1'b0 || o_err[0] !== 1'b0) begin
            n_err++;
            $display("FAIL single_digit: got val=%h dp=%b err=%b, required 3 0 0",
                     o_value[3:0], o_dp[0], o_err[0]);
        end
        check_drained("single");
    endtask

    task automatic test_full_frame();
        logic [7:0] pats [4];
        pats = '{8'b10011111, 8'b00100101, 8'b01001001, 8'b00000000};
        for (int d = 0; d < 4; d++) begin
            drive(~(4'b0001 << d), pats[d]);
            predict(d, pats[d], cyc + 19);
            repeat (40) @(negedge clk);
        end
        n_vec++;
        if (o_value !== 16'h8521 || o_dp !== 4'b1000) begin
            n_err++;
            $display("FAIL full_frame: got value=%h dp=%b, required 8521 1000", o_value, o_dp);
        end
        check_drained("frame");
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 6; k++) begin
            drive(4'b1101, 8'b00000011);
            repeat (8) @(negedge clk);
            drive(4'b1101, 8'b11111111);
        end
        drive(4'b1101, 8'b00000011);
        predict(1, 8'b00000011, cyc + 19);
        repeat (30) @(negedge clk);
        n_vec++;
        if (o_value[7:4] !== 4'd0) begin
            n_err++;
            $display("FAIL glitch_value: got %h, required 0", o_value[7:4]);
        end
        check_drained("glitch");
    endtask

    task automatic test_invalid_and_illegal();
        drive(4'b1011, 8'b11110001);
        predict(2, 8'b11110001, cyc + 19);
        repeat (30) @(negedge clk);
        n_vec++;
        if (o_err[2] !== 1'b1 || o_value[11:8] !== 4'd5 || o_blank[2] !== 1'b0) begin
            n_err++;
            $display("FAIL invalid_pattern: got err=%b val=%h blank=%b, required 1 5 0",
                     o_err[2], o_value[11:8], o_blank[2]);
        end
        drive(4'b1100, 8'b00000011);
        repeat (50) @(negedge clk);
        check_drained("illegal");
    endtask

    task automatic test_reset_mid();
        drive(4'b0111, 8'b00000011);
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (o_value !== 16'hFFFF || o_blank !== 4'hF || o_dp !== 4'h0 || o_err !== 4'h0
            || o_update !== 4'h0) begin
            n_err++;
            $display("FAIL mid_reset: got value=%h blank=%b dp=%b err=%b upd=%b, required reset",
                     o_value, o_blank, o_dp, o_err, o_update);
        end
        @(negedge clk);
        rst_n = 1'b1;
        predict(3, 8'b00000011, cyc + 19);
        repeat (30) @(negedge clk);
        n_vec++;
        if (o_value !== 16'h0FFF) begin
            n_err++;
            $display("FAIL recapture_value: got %h, required 0fff", o_value);
        end
        check_drained("midreset");
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_full_frame();
        test_glitch();
        test_invalid_and_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
